// File: rtl/board_read_arbiter.sv
// board_read_arbiter: round-robin arbitration of the board memory read port among win checker, renderer and debug.
// Optional macro DEBUG_PORT_EN enables the debug requester; otherwise the ring is W<->R only.
`default_nettype none

module board_read_arbiter #(
   parameter int ROWS = 6,
   parameter int COLS = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       board_wr,
   input  logic       req_w,
   input  logic       req_r,
   input  logic       req_d,
   input  logic [2:0] row_w,
   input  logic [2:0] row_r,
   input  logic [2:0] row_d,
   input  logic [2:0] col_w,
   input  logic [2:0] col_r,
   input  logic [2:0] col_d,
   output logic       gnt_w,
   output logic       gnt_r,
   output logic       gnt_d,
   output logic       rsp_valid_w,
   output logic       rsp_valid_r,
   output logic       rsp_valid_d,
   output logic [1:0] rsp_data,
   output logic       mem_rd_en,
   output logic [2:0] mem_rd_row,
   output logic [2:0] mem_rd_col,
   input  logic [1:0] mem_rd_data
);

   typedef enum logic [1:0] {PTR_W = 2'd0, PTR_R = 2'd1, PTR_D = 2'd2} ptr_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_W = 2'd1, OWN_R = 2'd2, OWN_D = 2'd3} owner_t;

   localparam logic [3:0] ROWS_LIM = 4'(ROWS);
   localparam logic [3:0] COLS_LIM = 4'(COLS);

   ptr_t       ptr, ptr_nxt;
   owner_t     owner, owner_nxt;
   logic       oob, oob_nxt;
   logic       elig_w, elig_r, elig_d;
   logic       any_gnt, in_range;
   logic [2:0] sel_row, sel_col;

   // Board writes own the memory port, and reset suppresses all grants.
   assign elig_w = req_w & ~board_wr & ~rst;
   assign elig_r = req_r & ~board_wr & ~rst;
`ifdef DEBUG_PORT_EN
   assign elig_d = req_d & ~board_wr & ~rst;
`else
   assign elig_d = req_d & 1'b0;
`endif

   always_comb begin
      gnt_w     = 1'b0;
      gnt_r     = 1'b0;
      gnt_d     = 1'b0;
      ptr_nxt   = ptr;
      owner_nxt = OWN_NONE;
      sel_row   = 3'd0;
      sel_col   = 3'd0;

      unique case (ptr)
         PTR_R: begin
            if (elig_r)      gnt_r = 1'b1;
            else if (elig_d) gnt_d = 1'b1;
            else if (elig_w) gnt_w = 1'b1;
         end
         PTR_D: begin
            if (elig_d)      gnt_d = 1'b1;
            else if (elig_w) gnt_w = 1'b1;
            else if (elig_r) gnt_r = 1'b1;
         end
         default: begin
            if (elig_w)      gnt_w = 1'b1;
            else if (elig_r) gnt_r = 1'b1;
            else if (elig_d) gnt_d = 1'b1;
         end
      endcase

      if (gnt_w) begin
         sel_row   = row_w;
         sel_col   = col_w;
         owner_nxt = OWN_W;
         ptr_nxt   = PTR_R;
      end
      if (gnt_r) begin
         sel_row   = row_r;
         sel_col   = col_r;
         owner_nxt = OWN_R;
`ifdef DEBUG_PORT_EN
         ptr_nxt   = PTR_D;
`else
         ptr_nxt   = PTR_W;
`endif
      end
      if (gnt_d) begin
         sel_row   = row_d;
         sel_col   = col_d;
         owner_nxt = OWN_D;
         ptr_nxt   = PTR_W;
      end

      any_gnt    = gnt_w | gnt_r | gnt_d;
      in_range   = ({1'b0, sel_row} < ROWS_LIM) && ({1'b0, sel_col} < COLS_LIM);
      // Out-of-range reads still get a response slot, but never touch memory.
      mem_rd_en  = any_gnt & in_range;
      oob_nxt    = any_gnt & ~in_range;
      mem_rd_row = sel_row;
      mem_rd_col = sel_col;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= PTR_W;
         owner <= OWN_NONE;
         oob   <= 1'b0;
      end else begin
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         oob   <= oob_nxt;
      end
   end

   assign rsp_valid_w = (owner == OWN_W);
   assign rsp_valid_r = (owner == OWN_R);
`ifdef DEBUG_PORT_EN
   assign rsp_valid_d = (owner == OWN_D);
`else
   assign rsp_valid_d = 1'b0;
`endif
   assign rsp_data = ((owner != OWN_NONE) && !oob) ? mem_rd_data : 2'b00;

endmodule

`default_nettype wire

// File: doc/board_read_arbiter.md
# board_read_arbiter

Shares the single synchronous read port of the Connect Four board memory between three requesters: the win checker, the display renderer and the debug controller. One grant per cycle, round-robin among active requesters. Piece writes from the move logic have absolute priority and block all grants. Each requester gets a per-port response with fixed latency. Out-of-range coordinates are answered without touching memory.

## Interface
Parameters:
- ROWS, 6, number of board rows (valid row 0..ROWS-1)
- COLS, 7, number of board columns (valid col 0..COLS-1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- board_wr  in  1  move logic is writing the board this cycle; read port unavailable
- req_w, req_r, req_d  in  1 each  read request: win checker, renderer, debug
- row_w, row_r, row_d  in  3 each  requested row, held with req until granted
- col_w, col_r, col_d  in  3 each  requested column, held with req until granted
- gnt_w, gnt_r, gnt_d  out  1 each  request accepted this cycle (combinational, one-hot or zero)
- rsp_valid_w, rsp_valid_r, rsp_valid_d  out  1 each  response data valid (registered)
- rsp_data  out  2  piece code for the port whose rsp_valid is high (00 empty, 01 P1, 10 P2)
- mem_rd_en  out  1  board memory read strobe
- mem_rd_row  out  3  board memory read row
- mem_rd_col  out  3  board memory read column
- mem_rd_data  in  2  board memory output, valid the cycle after mem_rd_en

## Operation
- Eligible requesters are those with req high.
- While board_wr=1, no requester is eligible.
- Round-robin pointer ptr cycles W→R→D→W. Search starts at ptr. The first eligible port in that order is granted.
- On a grant, ptr advances to the port after the granted one. With no grant, ptr holds.
- Granted request in range (row<ROWS and col<COLS):
  - mem_rd_en=1 and mem_rd_row/col are driven from the granted port, combinationally in the same cycle.
- Granted request out of range:
  - mem_rd_en=0.
  - The response still occurs at normal latency, with rsp_data=00.
- With no grant: mem_rd_en=0, and mem_rd_row/col=0.
- Response tracking is two registers: owner (2 bits: none/W/R/D) and oob (out-of-range flag), both loaded at every edge.
- Response cycle output:
  - rsp_valid_<owner>=1 for exactly one cycle.
  - rsp_data = oob ? 00 : mem_rd_data.
  - rsp_data=00 when no rsp_valid is high.
- A requester may deassert req only after gnt. It may issue a new request in the cycle after gnt, including the cycle its response arrives.
- Reset values: ptr=W, owner=none, oob=0. Consequently all rsp_valid=0 and rsp_data=00. All gnt and mem_rd_en are forced 0 while rst=1.

## Timing
- Cycle t: req sampled, gnt and mem_rd_* asserted.
- Cycle t+1: rsp_valid high with rsp_data. Latency is 1 cycle from gnt.
- Throughput: one read per cycle total, back-to-back grants allowed.
- Worst-case wait for any port holding req with board_wr low: 2 cycles.
- board_wr stalls add cycles one-for-one.
- Simultaneous req from all three with ptr=W: grants in order W, R, D on consecutive cycles.
- board_wr rising in the same cycle as a pending response: the response is still delivered. Only new grants are blocked.
- rst asserted mid-operation: any in-flight response is dropped (no rsp_valid after reset release). The requester must re-request.

## Configuration
- DEBUG_PORT_EN defined:
  - The debug port is arbitrated as above.
- DEBUG_PORT_EN undefined:
  - req_d is ignored, and gnt_d and rsp_valid_d are tied 0.
  - The round-robin is W↔R only.
  - The owner encoding never takes the D value.
  - Port list is unchanged.

## Test plan
- Reset, then req_r=1, row_r=2, col_r=3, board memory holding 01 at (2,3):
  - cycle 0: gnt_r=1, mem_rd_en=1, mem_rd_row/col=2/3.
  - cycle 1: rsp_valid_r=1, rsp_data=01.
- All three req held continuously from reset:
  - grants W,R,D,W,R,D on consecutive cycles.
  - each rsp_valid follows its gnt by exactly 1 cycle.
- board_wr=1 for 3 cycles with req_w=1: gnt_w=0 during the stall, gnt_w=1 on the first cycle board_wr=0.
- req_d with row_d=6, col_d=0:
  - gnt_d=1 with mem_rd_en=0.
  - next cycle rsp_valid_d=1, rsp_data=00, even when mem_rd_data=10.
- rst pulsed the cycle after gnt_w: no rsp_valid_w appears, and after release ptr=W (first grant goes to W when W and R both request).
- Build without DEBUG_PORT_EN, all req high: gnt_d never asserts, and grants alternate W,R.
